// File: rtl/pio_in_pkg.sv
// Shared definitions for the pio_in_edge_irq input port: register map and a clog2 helper.
package pio_in_pkg;

    localparam int REG_ADDR_W = 3;

    localparam logic [REG_ADDR_W-1:0] ADDR_DATA       = 3'd0;
    localparam logic [REG_ADDR_W-1:0] ADDR_RISE_EN    = 3'd1;
    localparam logic [REG_ADDR_W-1:0] ADDR_IRQ_MASK   = 3'd2;
    localparam logic [REG_ADDR_W-1:0] ADDR_EDGE_CAP   = 3'd3;
    localparam logic [REG_ADDR_W-1:0] ADDR_FALL_EN    = 3'd4;
    localparam logic [REG_ADDR_W-1:0] ADDR_LEVEL_MODE = 3'd5;
    localparam logic [REG_ADDR_W-1:0] ADDR_IRQ_STATUS = 3'd6;

    function automatic int clog2(input int value);
        int result;
        result = 0;
        for (int v = value - 1; v > 0; v = v >> 1) begin
            result = result + 1;
        end
        return result;
    endfunction

endpackage

// File: rtl/pio_in_bit_filter.sv
// One input bit: SYNC_STAGES-deep synchroniser, plus a stable-count debounce filter
// when PIO_IN_DEBOUNCE_EN is defined (otherwise f is the synchroniser output).
module pio_in_bit_filter
    import pio_in_pkg::*;
#(
    parameter int SYNC_STAGES     = 2,
    parameter int DEBOUNCE_CYCLES = 1000
) (
    input  logic clk,
    input  logic reset_n,
    input  logic in_bit,
    output logic f
);

    logic [SYNC_STAGES-1:0] sync_q;
    logic [SYNC_STAGES-1:0] sync_d;
    logic                   s;

    always_comb begin
        sync_d = {sync_q[SYNC_STAGES-2:0], in_bit};
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            sync_q <= '0;
        end else begin
            sync_q <= sync_d;
        end
    end

    assign s = sync_q[SYNC_STAGES-1];

`ifdef PIO_IN_DEBOUNCE_EN
    localparam int               CNT_W    = clog2(DEBOUNCE_CYCLES + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;
    logic             f_q;
    logic             f_d;

    // Any cycle where s agrees with f restarts the count, so only an
    // unbroken run of DEBOUNCE_CYCLES differing cycles moves f.
    always_comb begin
        cnt_d = '0;
        f_d   = f_q;
        if (s != f_q) begin
            if (cnt_q == CNT_LAST) begin
                f_d = s;
            end else begin
                cnt_d = cnt_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            cnt_q <= '0;
            f_q   <= 1'b0;
        end else begin
            cnt_q <= cnt_d;
            f_q   <= f_d;
        end
    end

    assign f = f_q;
`else
    logic unused_debounce;
    assign unused_debounce = (DEBOUNCE_CYCLES > 0);
    assign f = s;
`endif

endmodule

// File: rtl/pio_in_edge_irq.sv
// Avalon-MM input PIO with per-bit edge capture (W1C), edge/level IRQ mode and one masked irq.
// Define PIO_IN_DEBOUNCE_EN to add a DEBOUNCE_CYCLES stable-count filter on every input bit.
module pio_in_edge_irq
    import pio_in_pkg::*;
#(
    parameter int WIDTH           = 8,
    parameter int SYNC_STAGES     = 2,
    parameter int DEBOUNCE_CYCLES = 1000
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic [REG_ADDR_W-1:0] address,
    input  logic                  chipselect,
    input  logic                  write_n,
    input  logic [31:0]           writedata,
    output logic [31:0]           readdata,
    input  logic [WIDTH-1:0]      in_port,
    output logic                  irq
);

    logic [WIDTH-1:0] f;
    logic [WIDTH-1:0] rise;
    logic [WIDTH-1:0] fall;
    logic [WIDTH-1:0] ev;
    logic [WIDTH-1:0] pend;
    logic [WIDTH-1:0] irq_status;
    logic [WIDTH-1:0] wr_data;
    logic [WIDTH-1:0] w1c;
    logic             wr_en;

    logic [WIDTH-1:0] rise_en_q,    rise_en_d;
    logic [WIDTH-1:0] irq_mask_q,   irq_mask_d;
    logic [WIDTH-1:0] edge_cap_q,   edge_cap_d;
    logic [WIDTH-1:0] fall_en_q,    fall_en_d;
    logic [WIDTH-1:0] level_mode_q, level_mode_d;
    logic [WIDTH-1:0] f_prev_q,     f_prev_d;
    logic [31:0]      readdata_q,   readdata_d;

    for (genvar i = 0; i < WIDTH; i++) begin : g_bit
        pio_in_bit_filter #(
            .SYNC_STAGES     (SYNC_STAGES),
            .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES)
        ) u_filter (
            .clk     (clk),
            .reset_n (reset_n),
            .in_bit  (in_port[i]),
            .f       (f[i])
        );
    end

    logic unused_wdata;
    assign unused_wdata = ^writedata;

    assign wr_en   = chipselect & ~write_n;
    assign wr_data = writedata[WIDTH-1:0];

    always_comb begin
        rise       = f & ~f_prev_q;
        fall       = ~f & f_prev_q;
        ev         = (rise & rise_en_q) | (fall & fall_en_q);
        pend       = (level_mode_q & f) | (~level_mode_q & edge_cap_q);
        irq_status = pend & irq_mask_q;
        f_prev_d   = f;

        rise_en_d    = rise_en_q;
        irq_mask_d   = irq_mask_q;
        fall_en_d    = fall_en_q;
        level_mode_d = level_mode_q;
        w1c          = '0;
        if (wr_en) begin
            case (address)
                ADDR_RISE_EN:    rise_en_d    = wr_data;
                ADDR_IRQ_MASK:   irq_mask_d   = wr_data;
                ADDR_EDGE_CAP:   w1c          = wr_data;
                ADDR_FALL_EN:    fall_en_d    = wr_data;
                ADDR_LEVEL_MODE: level_mode_d = wr_data;
                default: ;
            endcase
        end
        // A new event is ORed in after the clear so it survives a same-cycle W1C.
        edge_cap_d = (edge_cap_q & ~w1c) | ev;

        case (address)
            ADDR_DATA:       readdata_d = 32'(f);
            ADDR_RISE_EN:    readdata_d = 32'(rise_en_q);
            ADDR_IRQ_MASK:   readdata_d = 32'(irq_mask_q);
            ADDR_EDGE_CAP:   readdata_d = 32'(edge_cap_q);
            ADDR_FALL_EN:    readdata_d = 32'(fall_en_q);
            ADDR_LEVEL_MODE: readdata_d = 32'(level_mode_q);
            ADDR_IRQ_STATUS: readdata_d = 32'(irq_status);
            default:         readdata_d = 32'h0;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            rise_en_q    <= '0;
            irq_mask_q   <= '0;
            edge_cap_q   <= '0;
            fall_en_q    <= '0;
            level_mode_q <= '0;
            f_prev_q     <= '0;
            readdata_q   <= '0;
        end else begin
            rise_en_q    <= rise_en_d;
            irq_mask_q   <= irq_mask_d;
            edge_cap_q   <= edge_cap_d;
            fall_en_q    <= fall_en_d;
            level_mode_q <= level_mode_d;
            f_prev_q     <= f_prev_d;
            readdata_q   <= readdata_d;
        end
    end

    assign readdata = readdata_q;
    assign irq      = |irq_status;

endmodule

// File: tb/tb_pio_in_edge_irq.sv
// Directed and randomised bench for pio_in_edge_irq against a behavioural register-map model.
module tb_pio_in_edge_irq;

    localparam int W    = 8;
    localparam int SYNC = 2;
    localparam int DB   = 4;
`ifdef PIO_IN_DEBOUNCE_EN
    localparam int LAT = SYNC + DB;
`else
    localparam int LAT = SYNC;
`endif

    logic         clk        = 1'b0;
    logic         reset_n    = 1'b0;
    logic [2:0]   address    = 3'd0;
    logic         chipselect = 1'b0;
    logic         write_n    = 1'b1;
    logic [31:0]  writedata  = 32'h0;
    logic [31:0]  readdata;
    logic [W-1:0] in_port    = '0;
    logic         irq;

    int tests = 0;
    int fails = 0;

    logic [W-1:0] m_rise, m_mask, m_cap, m_fall, m_level, m_fprev;
    logic [W-1:0] m_sq [SYNC];
    logic [31:0]  m_rd;
    logic         m_irq;
`ifdef PIO_IN_DEBOUNCE_EN
    logic [W-1:0] m_f;
    int           m_run [W];
`endif

    pio_in_edge_irq #(
        .WIDTH           (W),
        .SYNC_STAGES     (SYNC),
        .DEBOUNCE_CYCLES (DB)
    ) dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .address    (address),
        .chipselect (chipselect),
        .write_n    (write_n),
        .writedata  (writedata),
        .readdata   (readdata),
        .in_port    (in_port),
        .irq        (irq)
    );

    always #5 clk = ~clk;

    function automatic logic [W-1:0] model_f();
`ifdef PIO_IN_DEBOUNCE_EN
        return m_f;
`else
        return m_sq[SYNC-1];
`endif
    endfunction

    function automatic logic model_irq_now();
        logic [W-1:0] fv;
        fv = model_f();
        return |(((m_level & fv) | (~m_level & m_cap)) & m_mask);
    endfunction

    task automatic model_reset();
        m_rise = '0; m_mask = '0; m_cap = '0; m_fall = '0; m_level = '0; m_fprev = '0;
        for (int i = 0; i < SYNC; i++) m_sq[i] = '0;
        m_rd  = 32'h0;
        m_irq = 1'b0;
`ifdef PIO_IN_DEBOUNCE_EN
        m_f = '0;
        for (int i = 0; i < W; i++) m_run[i] = 0;
`endif
    endtask

    task automatic model_step();
        logic [W-1:0] fo, ev, clr, pend, s_old;
        logic         we;
        fo    = model_f();
        s_old = m_sq[SYNC-1];
        ev    = ((fo & ~m_fprev) & m_rise) | ((~fo & m_fprev) & m_fall);
        pend  = (m_level & fo) | (~m_level & m_cap);
        case (address)
            3'd0:    m_rd = 32'(fo);
            3'd1:    m_rd = 32'(m_rise);
            3'd2:    m_rd = 32'(m_mask);
            3'd3:    m_rd = 32'(m_cap);
            3'd4:    m_rd = 32'(m_fall);
            3'd5:    m_rd = 32'(m_level);
            3'd6:    m_rd = 32'(pend & m_mask);
            default: m_rd = 32'h0;
        endcase
        we    = chipselect && !write_n;
        clr   = (we && address == 3'd3) ? writedata[W-1:0] : '0;
        m_cap = (m_cap & ~clr) | ev;
        if (we) begin
            if (address == 3'd1) m_rise  = writedata[W-1:0];
            if (address == 3'd2) m_mask  = writedata[W-1:0];
            if (address == 3'd4) m_fall  = writedata[W-1:0];
            if (address == 3'd5) m_level = writedata[W-1:0];
        end
        m_fprev = fo;
`ifdef PIO_IN_DEBOUNCE_EN
        for (int i = 0; i < W; i++) begin
            if (s_old[i] != m_f[i]) begin
                m_run[i] = m_run[i] + 1;
                if (m_run[i] == DB) begin
                    m_f[i]   = s_old[i];
                    m_run[i] = 0;
                end
            end else begin
                m_run[i] = 0;
            end
        end
`endif
        for (int i = SYNC - 1; i > 0; i--) m_sq[i] = m_sq[i-1];
        m_sq[0] = in_port;
        m_irq   = model_irq_now();
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        if (!reset_n) model_reset();
        else model_step();
        @(negedge clk);
        check("model_readdata", readdata, m_rd);
        check("model_irq", 32'(irq), 32'(m_irq));
    endtask

    task automatic wr(input logic [2:0] a, input logic [31:0] d);
        address    = a;
        writedata  = d;
        chipselect = 1'b1;
        write_n    = 1'b0;
        cyc();
        chipselect = 1'b0;
        write_n    = 1'b1;
    endtask

    task automatic rd(input string tag, input logic [2:0] a, input logic [31:0] exp);
        address = a;
        cyc();
        check(tag, readdata, exp);
    endtask

    initial begin
        model_reset();
        repeat (3) cyc();
        check("rst_readdata", readdata, 32'h0);
        check("rst_irq", 32'(irq), 32'h0);
        reset_n = 1'b1;
        for (int a = 0; a < 8; a++) rd("reset_read", 3'(a), 32'h0);

        // Rising edge on bit 0 with irq enabled, then W1C.
        wr(3'd1, 32'h01);
        wr(3'd2, 32'h01);
        in_port = 8'h01;
        repeat (LAT) cyc();
        check("t2_irq_before", 32'(irq), 32'h0);
        address = 3'd3;
        cyc();
        check("t2_irq_rise", 32'(irq), 32'h1);
        cyc();
        check("t2_edge_cap", readdata, 32'h01);
        wr(3'd3, 32'h01);
        check("t2_irq_cleared", 32'(irq), 32'h0);

        // Falling-only capture on bit 7, irq masked.
        wr(3'd1, 32'h0);
        wr(3'd2, 32'h0);
        wr(3'd4, 32'h80);
        wr(3'd3, 32'hFF);
        in_port = 8'h81;
        repeat (5) cyc();
        in_port = 8'h01;
        repeat (LAT + 2) cyc();
        rd("t3_edge_cap", 3'd3, 32'h80);
        rd("t3_irq_status", 3'd6, 32'h0);
        check("t3_irq", 32'(irq), 32'h0);

        // Falling event lands on the same edge as a W1C of that bit.
        wr(3'd3, 32'h80);
        in_port = 8'h81;
        repeat (LAT + 2) cyc();
        in_port = 8'h01;
        repeat (LAT) cyc();
        wr(3'd3, 32'h80);
        rd("t4_cap_kept", 3'd3, 32'h80);
        wr(3'd3, 32'h80);
        rd("t4_cap_cleared", 3'd3, 32'h0);

        // Level mode on bit 1.
        wr(3'd4, 32'h0);
        wr(3'd1, 32'h02);
        wr(3'd5, 32'h02);
        wr(3'd2, 32'h02);
        in_port = 8'h03;
        repeat (LAT - 1) cyc();
        check("t5_irq_pre", 32'(irq), 32'h0);
        cyc();
        check("t5_irq_level", 32'(irq), 32'h1);
        wr(3'd3, 32'h02);
        check("t5_irq_w1c_a", 32'(irq), 32'h1);
        wr(3'd3, 32'h02);
        check("t5_irq_w1c_b", 32'(irq), 32'h1);
        in_port = 8'h01;
        repeat (LAT - 1) cyc();
        check("t5_irq_hold", 32'(irq), 32'h1);
        cyc();
        check("t5_irq_drop", 32'(irq), 32'h0);

        wr(3'd5, 32'h0);
        wr(3'd3, 32'hFF);
        wr(3'd1, 32'h04);
        wr(3'd2, 32'h04);
`ifdef PIO_IN_DEBOUNCE_EN
        in_port = 8'h05;
        repeat (3) cyc();
        in_port = 8'h01;
        repeat (LAT + 4) cyc();
        rd("t6_glitch_data", 3'd0, 32'h01);
        rd("t6_glitch_cap", 3'd3, 32'h0);
        check("t6_glitch_irq", 32'(irq), 32'h0);
        in_port = 8'h05;
        repeat (LAT) cyc();
        check("t6_irq_pre", 32'(irq), 32'h0);
        cyc();
        check("t6_irq_set", 32'(irq), 32'h1);
        rd("t6_data", 3'd0, 32'h05);
        rd("t6_cap", 3'd3, 32'h04);
`else
        in_port = 8'h05;
        cyc();
        in_port = 8'h01;
        repeat (LAT + 2) cyc();
        rd("t6_pulse_cap", 3'd3, 32'h04);
        check("t6_pulse_irq", 32'(irq), 32'h1);
`endif

        // Asynchronous reset mid-operation, input held high through release.
        wr(3'd5, 32'h01);
        wr(3'd2, 32'h01);
        address = 3'd0;
        cyc();
        in_port = 8'hFF;
        #2 reset_n = 1'b0;
        #1;
        check("async_rst_readdata", readdata, 32'h0);
        check("async_rst_irq", 32'(irq), 32'h0);
        model_reset();
        repeat (2) cyc();
        reset_n = 1'b1;
        repeat (LAT + 3) cyc();
        rd("rst_release_cap", 3'd3, 32'h0);
        check("rst_release_irq", 32'(irq), 32'h0);

        for (int n = 0; n < 400; n++) begin
            if ($urandom_range(0, 5) == 0) in_port = in_port ^ 8'($urandom_range(0, 255));
            address   = 3'($urandom_range(0, 7));
            writedata = $urandom;
            case ($urandom_range(0, 3))
                0:       begin chipselect = 1'b1; write_n = 1'b0; end
                1:       begin chipselect = 1'b1; write_n = 1'b1; end
                2:       begin chipselect = 1'b0; write_n = 1'b0; end
                default: begin chipselect = 1'b0; write_n = 1'b1; end
            endcase
            cyc();
        end
        chipselect = 1'b0;
        write_n    = 1'b1;
        repeat (2) cyc();

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
